// File: rtl/ahb_gpio_pkg.sv
// ahb_gpio_pkg: register offsets, HTRANS encodings and interrupt enums for ahb_gpio_irq.
package ahb_gpio_pkg;
    localparam logic [7:0] OFF_DATA = 8'h00, OFF_DIR = 8'h04, OFF_OUTSET = 8'h08, OFF_OUTCLR = 8'h0C;
    localparam logic [7:0] OFF_INTEN = 8'h10, OFF_INTTYPE = 8'h14, OFF_INTPOL = 8'h18, OFF_INTSTAT = 8'h1C;
    localparam logic [1:0] HTRANS_IDLE = 2'b00, HTRANS_BUSY = 2'b01, HTRANS_NONSEQ = 2'b10, HTRANS_SEQ = 2'b11;
    typedef enum logic {INT_LEVEL = 1'b0, INT_EDGE = 1'b1} int_type_e;
    typedef enum logic {POL_LOW = 1'b0, POL_HIGH = 1'b1} int_pol_e;
endpackage

// File: rtl/ahb_gpio_if.sv
// ahb_gpio_if: AHB-Lite slave-side bus signals with master/slave modports.
interface ahb_gpio_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    modport master (output HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA, input HREADYOUT, HRDATA);
    modport slave (input HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA, output HREADYOUT, HRDATA);
endinterface

// File: rtl/gpio_in_cond.sv
// gpio_in_cond: per-pin synchroniser, optional debounce (GPIO_DEBOUNCE_EN) and rise/fall pulses.
module gpio_in_cond #(
    parameter int WIDTH = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] val_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= pin_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= val_o;
        end
`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] filt_q, filt_d;
    // a 1-bit input that differs from the filtered value can only hold one value, so any run is consecutive
    always_comb
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = (sync_q[SYNC_STAGES-1][i] == filt_q[i] || cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) ? '0 : cnt_q[i] + 1'b1;
            filt_d[i] = (sync_q[SYNC_STAGES-1][i] != filt_q[i] && cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) ? sync_q[SYNC_STAGES-1][i] : filt_q[i];
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            filt_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    assign val_o = filt_q;
`else
    assign val_o = sync_q[SYNC_STAGES-1];
`endif
    assign rise_o = val_o & ~prev_q;
    assign fall_o = ~val_o & prev_q;
endmodule

// File: rtl/ahb_gpio_irq.sv
// ahb_gpio_irq: zero-wait AHB-Lite GPIO with per-bit direction, set/clear and edge/level interrupts.
// Define GPIO_DEBOUNCE_EN to insert a debounce filter after the input synchroniser.
module ahb_gpio_irq
    import ahb_gpio_pkg::*;
#(
    parameter int GPIO_WIDTH = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahb_gpio_if.slave             bus,
    input  logic [GPIO_WIDTH-1:0] GPIOIN,
    output logic [GPIO_WIDTH-1:0] GPIOOUT,
    output logic [GPIO_WIDTH-1:0] GPIOEN,
    output logic [GPIO_WIDTH-1:0] GPIOINT,
    output logic                  COMBINT
);
    logic                  sel_q, write_q, trans_q;
    logic [7:0]            addr_q;
    logic [GPIO_WIDTH-1:0] dout_q, dout_d, dir_q, dir_d, inten_q, inten_d;
    logic [GPIO_WIDTH-1:0] inttype_q, inttype_d, intpol_q, intpol_d, intstat_q, intstat_d;
    logic [GPIO_WIDTH-1:0] din, rise, fall, irq_set, wdata, rd;
    logic                  wr, rd_en;

    gpio_in_cond #(.WIDTH(GPIO_WIDTH), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_in (
        .clk(HCLK), .rst_n(HRESETn), .pin_i(GPIOIN), .val_o(din), .rise_o(rise), .fall_o(fall)
    );

    assign wdata = bus.HWDATA[GPIO_WIDTH-1:0];
    // the data phase only completes on a cycle with HREADY high
    assign wr    = sel_q & trans_q & write_q & bus.HREADY;
    assign rd_en = sel_q & trans_q & ~write_q;

    always_comb
        for (int i = 0; i < GPIO_WIDTH; i++)
            irq_set[i] = (inttype_q[i] == INT_EDGE) ? ((intpol_q[i] == POL_HIGH) ? rise[i] : fall[i]) : (din[i] == intpol_q[i]);

    always_comb begin
        dout_d = !wr ? dout_q :
                 addr_q == OFF_DATA   ? (dout_q & ~dir_q) | (wdata & dir_q) :
                 addr_q == OFF_OUTSET ? dout_q | wdata :
                 addr_q == OFF_OUTCLR ? dout_q & ~wdata : dout_q;
        dir_d     = (wr && addr_q == OFF_DIR)     ? wdata : dir_q;
        inten_d   = (wr && addr_q == OFF_INTEN)   ? wdata : inten_q;
        inttype_d = (wr && addr_q == OFF_INTTYPE) ? wdata : inttype_q;
        intpol_d  = (wr && addr_q == OFF_INTPOL)  ? wdata : intpol_q;
        intstat_d = (intstat_q & ~((wr && addr_q == OFF_INTSTAT) ? wdata : '0)) | irq_set;
    end

    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            sel_q     <= 1'b0;
            write_q   <= 1'b0;
            trans_q   <= 1'b0;
            addr_q    <= '0;
            dout_q    <= '0;
            dir_q     <= '0;
            inten_q   <= '0;
            inttype_q <= '0;
            intpol_q  <= '0;
            intstat_q <= '0;
        end else begin
            if (bus.HREADY) begin
                sel_q   <= bus.HSEL;
                write_q <= bus.HWRITE;
                trans_q <= bus.HTRANS[1];
                addr_q  <= bus.HADDR[7:0];
            end
            dout_q    <= dout_d;
            dir_q     <= dir_d;
            inten_q   <= inten_d;
            inttype_q <= inttype_d;
            intpol_q  <= intpol_d;
            intstat_q <= intstat_d;
        end

    always_comb begin
        rd = !rd_en ? '0 :
             addr_q == OFF_DATA    ? (dir_q & dout_q) | (~dir_q & din) :
             addr_q == OFF_DIR     ? dir_q :
             addr_q == OFF_INTEN   ? inten_q :
             addr_q == OFF_INTTYPE ? inttype_q :
             addr_q == OFF_INTPOL  ? intpol_q :
             addr_q == OFF_INTSTAT ? intstat_q : '0;
        bus.HRDATA = '0;
        bus.HRDATA[GPIO_WIDTH-1:0] = rd;
    end

    assign bus.HREADYOUT = 1'b1;
    assign GPIOOUT = dout_q;
    assign GPIOEN  = dir_q;
    assign GPIOINT = intstat_q & inten_q;
    assign COMBINT = |GPIOINT;
endmodule

// File: tb/tb_ahb_gpio_irq.sv
// tb_ahb_gpio_irq: directed bench for ahb_gpio_irq with hand-computed expectations.
module tb_ahb_gpio_irq;
    import ahb_gpio_pkg::*;
    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [15:0] gpio_in, gpio_out, gpio_en, gpio_int;
    logic        comb;
    logic [31:0] rdv;
    int          total = 0;
    int          bad = 0;

    ahb_gpio_if bus();

    ahb_gpio_irq #(.GPIO_WIDTH(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus), .GPIOIN(gpio_in),
        .GPIOOUT(gpio_out), .GPIOEN(gpio_en), .GPIOINT(gpio_int), .COMBINT(comb)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.HSEL = 1'b0;
        bus.HTRANS = HTRANS_IDLE;
        bus.HWRITE = 1'b0;
        bus.HADDR = '0;
        bus.HREADY = 1'b1;
    endtask

    task automatic addr_phase(input logic [7:0] a, input logic w);
        bus.HSEL = 1'b1;
        bus.HTRANS = HTRANS_NONSEQ;
        bus.HWRITE = w;
        bus.HADDR = {24'h0, a};
        bus.HREADY = 1'b1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        addr_phase(a, 1'b1);
        @(posedge HCLK); #1;
        idle();
        bus.HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        addr_phase(a, 1'b0);
        @(posedge HCLK); #1;
        idle();
        d = bus.HRDATA;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESETn = 1'b0;
        gpio_in = '0;
        bus.HWDATA = '0;
        idle();
        cycles(2);
        HRESETn = 1'b1;
        cycles(1);
        // reset asserted during the data phase of a DIR write
        addr_phase(OFF_DIR, 1'b1);
        @(posedge HCLK); #1;
        idle();
        bus.HWDATA = 32'hFFFF;
        #2 HRESETn = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        cycles(1);
        check("rst_gpioen", 32'(gpio_en), 32'h0);
        check("rst_gpioout", 32'(gpio_out), 32'h0);
        check("rst_combint", 32'(comb), 32'h0);
        rd(OFF_DIR, rdv);   check("rst_rd_dir", rdv, 32'h0);
        rd(OFF_DATA, rdv);  check("rst_rd_data", rdv, 32'h0);
        rd(OFF_INTEN, rdv); check("rst_rd_inten", rdv, 32'h0);
        // output data path
        wr(OFF_DIR, 32'h00FF);
        wr(OFF_DATA, 32'hABCD);
        check("data_masked", 32'(gpio_out), 32'h00CD);
        wr(OFF_OUTSET, 32'h0100);
        check("outset", 32'(gpio_out), 32'h01CD);
        wr(OFF_OUTCLR, 32'h0001);
        check("outclr", 32'(gpio_out), 32'h01CC);
        check("gpioen", 32'(gpio_en), 32'h00FF);
        rd(OFF_DATA, rdv);   check("rd_data_mix", rdv, 32'h00CC);
        rd(OFF_OUTSET, rdv); check("rd_outset", rdv, 32'h0);
        // input synchroniser latency
        wr(OFF_DIR, 32'h0);
        gpio_in = 16'h1234;
        rd(OFF_DATA, rdv); check("sync_early", rdv, 32'h0);
        rd(OFF_DATA, rdv); check("sync_late", rdv, 32'h1234);
        // rising-edge interrupt on pin 0, other pins level-high
        gpio_in = 16'h0;
        cycles(4);
        wr(OFF_INTPOL, 32'hFFFF);
        wr(OFF_INTTYPE, 32'h0001);
        wr(OFF_INTEN, 32'h0001);
        wr(OFF_INTSTAT, 32'hFFFF);
        rd(OFF_INTSTAT, rdv); check("intstat_clean", rdv, 32'h0);
        gpio_in = 16'h0001;
        cycles(4);
        rd(OFF_INTSTAT, rdv); check("edge_set", rdv, 32'h1);
        check("gpioint_edge", 32'(gpio_int), 32'h1);
        check("combint_edge", 32'(comb), 32'h1);
        wr(OFF_INTSTAT, 32'h1);
        rd(OFF_INTSTAT, rdv); check("edge_w1c", rdv, 32'h0);
        check("combint_w1c", 32'(comb), 32'h0);
        gpio_in = 16'h0;
        cycles(4);
        rd(OFF_INTSTAT, rdv); check("fall_no_set", rdv, 32'h0);
        // level-high on pin 3 resists W1C while active
        gpio_in = 16'h0008;
        cycles(4);
        rd(OFF_INTSTAT, rdv); check("level_set", rdv, 32'h8);
        wr(OFF_INTSTAT, 32'h8);
        rd(OFF_INTSTAT, rdv); check("level_hold", rdv, 32'h8);
        check("gpioint_masked", 32'(gpio_int), 32'h0);
        gpio_in = 16'h0;
        cycles(4);
        wr(OFF_INTSTAT, 32'h8);
        rd(OFF_INTSTAT, rdv); check("level_clear", rdv, 32'h0);
        // set wins over simultaneous W1C: rise pulse lands on the write's data-phase edge
        gpio_in = 16'h0001;
        cycles(1);
        wr(OFF_INTSTAT, 32'h1);
        rd(OFF_INTSTAT, rdv); check("set_wins", rdv, 32'h1);
        wr(OFF_INTSTAT, 32'h1);
        rd(OFF_INTSTAT, rdv); check("w1c_after", rdv, 32'h0);
        // address phase with HREADY low is not sampled
        addr_phase(OFF_DIR, 1'b1);
        bus.HREADY = 1'b0;
        @(posedge HCLK); #1;
        idle();
        bus.HWDATA = 32'hFFFF;
        @(posedge HCLK); #1;
        cycles(1);
        check("hready0_en", 32'(gpio_en), 32'h0);
        rd(OFF_DIR, rdv); check("hready0_dir", rdv, 32'h0);
        cycles(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
